// File: rtl/resp_arbiter_b.sv
// resp_arbiter_b
//   Round-robin arbiter that shares one fixed-latency responder among
//   N_REQ requesters. Each transaction runs IDLE -> ISSUE -> WAIT -> ACK,
//   and every output is registered.
//
//   Optional feature macro: RESP_ARBITER_B_TIMEOUT_EN
//     Adds a WAIT cycle counter and an ABORT state. An abort pulses err_out
//     once. Without the macro, WAIT never times out, err_out is tied to 0
//     and no counter exists.
//
// Parameters
//   N_REQ    number of requesters (2..8)
//   TIMEOUT  maximum WAIT cycles before abort (1..255, macro builds only)
//
// Ports
//   clk_b      in   1      sole clock, rising edge
//   reset_in   in   1      synchronous active-high reset
//   req_in     in   N_REQ  level request per requester
//   gnt_out    out  N_REQ  one-hot grant, held for the whole transaction
//   ack_out    out  N_REQ  one-cycle completion pulse to the winner
//   start_out  out  1      one-cycle start pulse to the responder
//   done_in    in   1      one-cycle completion pulse from the responder
//   busy_out   out  1      high whenever the FSM is not IDLE
//   err_out    out  1      one-cycle timeout-abort pulse
module resp_arbiter_b #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk_b,
  input  logic             reset_in,
  input  logic [N_REQ-1:0] req_in,
  output logic [N_REQ-1:0] gnt_out,
  output logic [N_REQ-1:0] ack_out,
  output logic             start_out,
  input  logic             done_in,
  output logic             busy_out,
  output logic             err_out
);

  localparam int PTR_W = $clog2(N_REQ);

  // Elaboration-time guard on the parameter ranges.
  if (N_REQ < 2 || N_REQ > 8) begin : g_badNReq
    $error("resp_arbiter_b: N_REQ must be in 2..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_badTimeout
    $error("resp_arbiter_b: TIMEOUT must be in 1..255");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACK
`ifdef RESP_ARBITER_B_TIMEOUT_EN
    , S_ABORT
`endif
  } state_t;

  state_t             r_state, w_stateNext;
  logic [PTR_W-1:0]   r_ptr, w_ptrNext;
  logic [PTR_W-1:0]   r_winner, w_winnerNext;
  logic [PTR_W-1:0]   w_pick;
  logic [PTR_W-1:0]   w_ptrAdvance;
  logic               w_found;
  logic [N_REQ-1:0]   r_gnt, w_gntNext;
  logic [N_REQ-1:0]   r_ack, w_ackNext;
  logic               r_start, w_startNext;
  logic               r_busy, w_busyNext;
`ifdef RESP_ARBITER_B_TIMEOUT_EN
  logic [7:0]         r_cnt, w_cntNext;
  logic               r_err, w_errNext;
`endif

  // The sum base + offs is always below 2*N_REQ, so one conditional
  // subtraction replaces a modulo.
  function automatic logic [PTR_W-1:0] wrapIdx(input int base, input int offs);
    int s;
    s = base + offs;
    if (s >= N_REQ) s = s - N_REQ;
    return PTR_W'(s);
  endfunction

  // Scan starts at the round-robin pointer, so the last winner
  // (ptr-1) is considered last.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && req_in[wrapIdx(int'(r_ptr), i)]) begin
        w_found = 1'b1;
        w_pick  = wrapIdx(int'(r_ptr), i);
      end
    end
  end

  assign w_ptrAdvance = (r_winner == PTR_W'(N_REQ - 1)) ? '0 : r_winner + PTR_W'(1);

  // Next-state and next-output logic. The outputs are computed here and
  // registered alongside the state.
  always_comb begin
    w_stateNext  = r_state;
    w_ptrNext    = r_ptr;
    w_winnerNext = r_winner;
    w_gntNext    = r_gnt;
    w_ackNext    = '0;
    w_startNext  = 1'b0;
`ifdef RESP_ARBITER_B_TIMEOUT_EN
    w_cntNext    = r_cnt;
    w_errNext    = 1'b0;
`endif

    case (r_state)
      S_IDLE: begin
        w_gntNext = '0;
        if (w_found) begin
          w_stateNext  = S_ISSUE;
          w_winnerNext = w_pick;
          w_gntNext    = N_REQ'(1) << w_pick;
          w_startNext  = 1'b1;
        end
      end

      S_ISSUE: begin
        w_stateNext = S_WAIT;
`ifdef RESP_ARBITER_B_TIMEOUT_EN
        w_cntNext   = 8'd1;
`endif
      end

      // If done_in arrives in the same cycle the count hits TIMEOUT,
      // the completion wins.
      S_WAIT: begin
        if (done_in) begin
          w_stateNext = S_ACK;
          w_ackNext   = r_gnt;
`ifdef RESP_ARBITER_B_TIMEOUT_EN
          w_cntNext   = 8'd0;
`endif
        end
`ifdef RESP_ARBITER_B_TIMEOUT_EN
        else if (r_cnt == 8'(TIMEOUT)) begin
          w_stateNext = S_ABORT;
          w_errNext   = 1'b1;
          w_cntNext   = 8'd0;
        end else begin
          w_cntNext   = r_cnt + 8'd1;
        end
`endif
      end

      S_ACK: begin
        w_stateNext = S_IDLE;
        w_gntNext   = '0;
        w_ptrNext   = w_ptrAdvance;
      end

`ifdef RESP_ARBITER_B_TIMEOUT_EN
      S_ABORT: begin
        w_stateNext = S_IDLE;
        w_gntNext   = '0;
        w_ptrNext   = w_ptrAdvance;
      end
`endif

      default: begin
        w_stateNext = S_IDLE;
        w_gntNext   = '0;
      end
    endcase

    w_busyNext = (w_stateNext != S_IDLE);
  end

  always_ff @(posedge clk_b) begin
    if (reset_in) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_winner <= '0;
      r_gnt    <= '0;
      r_ack    <= '0;
      r_start  <= 1'b0;
      r_busy   <= 1'b0;
`ifdef RESP_ARBITER_B_TIMEOUT_EN
      r_cnt    <= 8'd0;
      r_err    <= 1'b0;
`endif
    end else begin
      r_state  <= w_stateNext;
      r_ptr    <= w_ptrNext;
      r_winner <= w_winnerNext;
      r_gnt    <= w_gntNext;
      r_ack    <= w_ackNext;
      r_start  <= w_startNext;
      r_busy   <= w_busyNext;
`ifdef RESP_ARBITER_B_TIMEOUT_EN
      r_cnt    <= w_cntNext;
      r_err    <= w_errNext;
`endif
    end
  end

  assign gnt_out   = r_gnt;
  assign ack_out   = r_ack;
  assign start_out = r_start;
  assign busy_out  = r_busy;
`ifdef RESP_ARBITER_B_TIMEOUT_EN
  assign err_out   = r_err;
`else
  assign err_out   = 1'b0;
`endif

endmodule

// File: tb/tb_resp_arbiter_b.sv
// tb_resp_arbiter_b
//   Directed bench for resp_arbiter_b (N_REQ=4, TIMEOUT=15). A cycle-by-cycle
//   vector table covers the basic transaction, spurious done pulses, an early
//   request drop, reset in WAIT and re-eligibility. Hand-written sequences
//   cover round-robin rotation and the timeout behaviour. Timeout behaviour is
//   selected by RESP_ARBITER_B_TIMEOUT_EN.
module tb_resp_arbiter_b;

  logic       clk_b;
  logic       reset_in;
  logic [3:0] req_in;
  logic [3:0] gnt_out;
  logic [3:0] ack_out;
  logic       start_out;
  logic       done_in;
  logic       busy_out;
  logic       err_out;

  int assertCount = 0;
  int failCount   = 0;
  int propViolations = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [3:0] ack;
    logic       start;
    logic       busy;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  resp_arbiter_b #(
    .N_REQ   (4),
    .TIMEOUT (15)
  ) dut (
    .clk_b     (clk_b),
    .reset_in  (reset_in),
    .req_in    (req_in),
    .gnt_out   (gnt_out),
    .ack_out   (ack_out),
    .start_out (start_out),
    .done_in   (done_in),
    .busy_out  (busy_out),
    .err_out   (err_out)
  );

  initial clk_b = 1'b0;
  always #5 clk_b = ~clk_b;

  // Continuous checks: pulses are mutually exclusive, and grant and ack
  // are never multi-hot.
  always @(negedge clk_b) begin
    if ((start_out && err_out) || (start_out && (ack_out != 4'b0)) ||
        (err_out && (ack_out != 4'b0)) ||
        ($countones(gnt_out) > 1) || ($countones(ack_out) > 1))
      propViolations++;
  end

  task automatic applyStimulus(input logic rst, input logic [3:0] req, input logic done);
    reset_in = rst;
    req_in   = req;
    done_in  = done;
    @(posedge clk_b);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eGnt, input logic [3:0] eAck,
                             input logic eStart, input logic eBusy, input logic eErr);
    assertCount++;
    if ({gnt_out, ack_out, start_out, busy_out, err_out} !== {eGnt, eAck, eStart, eBusy, eErr}) begin
      failCount++;
      $display("[TB] FAIL %s: got gnt=%b ack=%b start=%b busy=%b err=%b, expected gnt=%b ack=%b start=%b busy=%b err=%b",
               name, gnt_out, ack_out, start_out, busy_out, err_out, eGnt, eAck, eStart, eBusy, eErr);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic addVec(input logic rst, input logic [3:0] req, input logic done,
                        input logic [3:0] gnt, input logic [3:0] ack,
                        input logic start, input logic busy, input logic err);
    vec_t v;
    v.rst = rst; v.req = req; v.done = done;
    v.gnt = gnt; v.ack = ack; v.start = start; v.busy = busy; v.err = err;
    vecs.push_back(v);
  endtask

  initial begin
    logic [3:0] expGnt;
    int         rrPtr;
    int         badCycles;

    reset_in = 1'b1;
    req_in   = 4'b0000;
    done_in  = 1'b0;

    //     rst  req      done  gnt      ack      start busy  err
    addVec(1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0); // reset
    addVec(1'b0, 4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0); // grant 2
    addVec(1'b0, 4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0); // WAIT
    addVec(1'b0, 4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0);
    addVec(1'b0, 4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b0, 1'b1, 1'b0); // ACK
    addVec(1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0); // IDLE, ptr=3
    addVec(1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0); // stray done in IDLE
    addVec(1'b0, 4'b0011, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0); // wrap to 0
    addVec(1'b0, 4'b0011, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0); // done in ISSUE ignored
    addVec(1'b0, 4'b0010, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0); // winner drops req
    addVec(1'b0, 4'b0010, 1'b1, 4'b0001, 4'b0001, 1'b0, 1'b1, 1'b0); // ack still issued
    addVec(1'b0, 4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0); // IDLE, ptr=1
    addVec(1'b0, 4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0); // grant 1
    addVec(1'b0, 4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1, 1'b0); // WAIT
    addVec(1'b1, 4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0); // reset in WAIT
    addVec(1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0); // stray done after reset
    addVec(1'b0, 4'b1001, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0); // ptr back to 0
    addVec(1'b0, 4'b1001, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0);
    addVec(1'b0, 4'b1001, 1'b1, 4'b0001, 4'b0001, 1'b0, 1'b1, 1'b0);
    addVec(1'b0, 4'b1001, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0); // ptr=1
    addVec(1'b0, 4'b1001, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b1, 1'b0); // held req 0 loses
    addVec(1'b0, 4'b1001, 1'b0, 4'b1000, 4'b0000, 1'b0, 1'b1, 1'b0);
    addVec(1'b0, 4'b1001, 1'b1, 4'b1000, 4'b1000, 1'b0, 1'b1, 1'b0);
    addVec(1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0); // ptr=0

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].done);
      checkOutput($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].ack,
                  vecs[i].start, vecs[i].busy, vecs[i].err);
    end

    // All four requesting; the responder answers three cycles after start.
    rrPtr = 0;
    for (int k = 0; k < 5; k++) begin
      expGnt = 4'b0001 << rrPtr;
      applyStimulus(1'b0, 4'b1111, 1'b0);
      checkOutput($sformatf("rr%0d_grant", k), expGnt, 4'b0000, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 4'b1111, 1'b0);
      checkOutput($sformatf("rr%0d_wait1", k), expGnt, 4'b0000, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 4'b1111, 1'b0);
      checkOutput($sformatf("rr%0d_wait2", k), expGnt, 4'b0000, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 4'b1111, 1'b1);
      checkOutput($sformatf("rr%0d_ack", k), expGnt, expGnt, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 4'b1111, 1'b0);
      checkOutput($sformatf("rr%0d_idle", k), 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
      rrPtr = (rrPtr + 1) % 4;
    end
    // The pointer now sits at 1.

`ifdef RESP_ARBITER_B_TIMEOUT_EN
    begin
      int errAt;
      int sawAck;
      errAt  = 0;
      sawAck = 0;
      applyStimulus(1'b0, 4'b0100, 1'b0);
      checkOutput("to_grant", 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0);
      for (int k = 1; k <= 30; k++) begin
        applyStimulus(1'b0, 4'b0100, 1'b0);
        if (ack_out != 4'b0000) sawAck = 1;
        if (err_out) begin
          errAt = k;
          break;
        end
      end
      checkValue("to_errCycle", errAt, 16);
      checkValue("to_noAck", sawAck, 0);
      applyStimulus(1'b0, 4'b0101, 1'b0);
      checkOutput("to_idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'b0101, 1'b0);
      checkOutput("to_nextGrant", 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0);

      badCycles = 0;
      for (int k = 1; k <= 15; k++) begin
        applyStimulus(1'b0, 4'b0101, 1'b0);
        if (gnt_out !== 4'b0001 || busy_out !== 1'b1 || err_out !== 1'b0 || ack_out !== 4'b0000)
          badCycles++;
      end
      checkValue("tb_waitCycles", badCycles, 0);
      applyStimulus(1'b0, 4'b0101, 1'b1);
      checkOutput("tb_doneAtLimit", 4'b0001, 4'b0001, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 4'b0000, 1'b0);
      checkOutput("tb_idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    end
`else
    applyStimulus(1'b0, 4'b0100, 1'b0);
    checkOutput("nt_grant", 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0);
    badCycles = 0;
    for (int k = 0; k < 1000; k++) begin
      applyStimulus(1'b0, 4'b0100, 1'b0);
      if (busy_out !== 1'b1 || err_out !== 1'b0 || gnt_out !== 4'b0100 || ack_out !== 4'b0000)
        badCycles++;
    end
    checkValue("nt_longWait", badCycles, 0);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    checkOutput("nt_ack", 4'b0100, 4'b0100, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    checkOutput("nt_idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
`endif

    checkValue("props_exclusive_onehot", propViolations, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
